// File: rtl/wport_arb_2_1.sv
// rtl/wport_arb_2_1.sv - 2:1 round-robin register-file write-port arbiter with a registered output stage
// Optional grant counters are built when WPORT_ARB_STATS_EN is defined.
module wport_arb_2_1 #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in0_valid,
   output logic              in0_ready,
   input  logic [ADDR_W-1:0] in0_addr,
   input  logic [DATA_W-1:0] in0_data,
   input  logic              in1_valid,
   output logic              in1_ready,
   input  logic [ADDR_W-1:0] in1_addr,
   input  logic [DATA_W-1:0] in1_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src
`ifdef WPORT_ARB_STATS_EN
   ,
   output logic [15:0]       gnt_cnt0,
   output logic [15:0]       gnt_cnt1
`endif
);

   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_src_q, out_src_d;
   logic              last_grant_q, last_grant_d;

   logic              stage_open;
   logic              gnt_idx;
   logic              in_xfer;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   // Grant decision deliberately ignores addr/data so ready never depends on payload.
   always_comb begin
      stage_open = !out_valid_q || out_ready;
      gnt_idx    = (in0_valid && in1_valid) ? ~last_grant_q : in1_valid;
      in_xfer    = rst_n && stage_open && (in0_valid || in1_valid);
      in0_ready  = in_xfer && !gnt_idx;
      in1_ready  = in_xfer && gnt_idx;
      sel_addr   = gnt_idx ? in1_addr : in0_addr;
      sel_data   = gnt_idx ? in1_data : in0_data;
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_addr_d   = out_addr_q;
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      last_grant_d = last_grant_q;
      if (in_xfer) begin
         last_grant_d = gnt_idx;
         // Writes to register 0 are accepted but dropped: the stage empties instead.
         if (sel_addr != '0) begin
            out_valid_d = 1'b1;
            out_addr_d  = sel_addr;
            out_data_d  = sel_data;
            out_src_d   = gnt_idx;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_addr_q   <= '0;
         out_data_q   <= '0;
         out_src_q    <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_addr_q   <= out_addr_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

`ifdef WPORT_ARB_STATS_EN
   logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
   logic [15:0] gnt_cnt1_q, gnt_cnt1_d;

   always_comb begin
      gnt_cnt0_d = gnt_cnt0_q;
      gnt_cnt1_d = gnt_cnt1_q;
      if (in0_ready && (gnt_cnt0_q != 16'hFFFF)) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
      if (in1_ready && (gnt_cnt1_q != 16'hFFFF)) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_cnt0_q <= '0;
         gnt_cnt1_q <= '0;
      end else begin
         gnt_cnt0_q <= gnt_cnt0_d;
         gnt_cnt1_q <= gnt_cnt1_d;
      end
   end

   assign gnt_cnt0 = gnt_cnt0_q;
   assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_wport_arb_2_1.sv
// tb/tb_wport_arb_2_1.sv - scoreboard testbench for wport_arb_2_1
// Counter checks are built when WPORT_ARB_STATS_EN is defined.
module tb_wport_arb_2_1;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in0_valid, in0_ready, in1_valid, in1_ready;
   logic [ADDR_W-1:0] in0_addr, in1_addr, out_addr;
   logic [DATA_W-1:0] in0_data, in1_data, out_data;
   logic              out_valid, out_ready, out_src;
`ifdef WPORT_ARB_STATS_EN
   logic [15:0]       gnt_cnt0, gnt_cnt1;
`endif

   int checks = 0;
   int failures = 0;
   logic [37:0] exp_q[$];

   always #5 clk = ~clk;

   wport_arb_2_1 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_addr(in0_addr), .in0_data(in0_data),
      .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_addr(in1_addr), .in1_data(in1_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
      .out_src(out_src)
`ifdef WPORT_ARB_STATS_EN
      , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic src, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      exp_q.push_back({src, a, d});
   endtask

   // Monitor: every presented-and-consumed write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write actual=%0h required=none", {out_src, out_addr, out_data});
         end else begin
            logic [37:0] e;
            e = exp_q.pop_front();
            if ({out_src, out_addr, out_data} !== e) begin
               failures++;
               $display("FAIL out_write actual=%0h required=%0h", {out_src, out_addr, out_data}, e);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      in0_valid = 1'b1; in1_valid = 1'b0;
      in0_addr = '0; in1_addr = '0; in0_data = '0; in1_data = '0;
      out_ready = 1'b1;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_in0_ready", in0_ready, 0);
      tick();
      rst_n = 1'b1;

      // Tie with out_ready=1: alternating grants starting at requester 0
      in0_valid = 1; in1_valid = 1;
      in0_addr = 3; in0_data = 32'h11111111;
      in1_addr = 4; in1_data = 32'h22222222;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rr_in0_ready", in0_ready, (k % 2 == 0));
         chk("rr_in1_ready", in1_ready, (k % 2 == 1));
         if (k > 0) chk("rr_out_valid", out_valid, 1);
         if (k % 2 == 0) push(0, 3, 32'h11111111);
         else            push(1, 4, 32'h22222222);
         tick();
      end
      in0_valid = 0; in1_valid = 0;
      @(negedge clk);
      chk("rr_last_valid", out_valid, 1);
      tick();
      @(negedge clk);
      chk("drain_empty", out_valid, 0);

      // Stall: in1 only, out_ready low for 3 cycles
      tick();
      in1_valid = 1; in1_addr = 7; in1_data = 32'hDEADBEEF; out_ready = 0;
      @(negedge clk);
      chk("stall_first_ready", in1_ready, 1);
      push(1, 7, 32'hDEADBEEF);
      tick();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_addr", out_addr, 7);
         chk("stall_data", out_data, 32'hDEADBEEF);
         chk("stall_src", out_src, 1);
         chk("stall_in1_ready", in1_ready, 0);
         chk("stall_in0_ready", in0_ready, 0);
         tick();
      end
      out_ready = 1;
      @(negedge clk);
      chk("stall_release_ready", in1_ready, 1);
      push(1, 7, 32'hDEADBEEF);
      tick();
      in1_valid = 0;
      @(negedge clk);
      chk("no_bubble_valid", out_valid, 1);
      tick();

      // $zero write: accepted, not forwarded, flips round-robin
      in0_valid = 1; in0_addr = 0; in0_data = 32'hFFFFFFFF;
      @(negedge clk);
      chk("zero_in0_ready", in0_ready, 1);
      tick();
      in0_valid = 0;
      @(negedge clk);
      chk("zero_not_fwd", out_valid, 0);
      tick();
      in0_valid = 1; in1_valid = 1;
      in0_addr = 5; in0_data = 32'h55555555;
      in1_addr = 6; in1_data = 32'h66666666;
      @(negedge clk);
      chk("zero_tie_in1", in1_ready, 1);
      chk("zero_tie_in0", in0_ready, 0);
      push(1, 6, 32'h66666666);
      tick();
      in0_valid = 0; in1_valid = 0;
      @(negedge clk);
      tick();

      // Continuous in0 stream
      in0_valid = 1; in0_addr = 9;
      for (int k = 0; k < 5; k++) begin
         in0_data = 32'h1000 + k;
         @(negedge clk);
         chk("stream_ready", in0_ready, 1);
         if (k > 0) begin
            chk("stream_valid", out_valid, 1);
            chk("stream_src", out_src, 0);
         end
         push(0, 9, 32'h1000 + k);
         tick();
      end
      in0_valid = 0;
      @(negedge clk);
      tick();

      // Async reset while FULL and stalled: held write is discarded
      in1_valid = 1; in1_addr = 2; in1_data = 32'hCAFEF00D; out_ready = 0;
      @(negedge clk);
      chk("prerst_in1_ready", in1_ready, 1);
      tick();
      in1_valid = 0; in0_valid = 1;
      chk("prerst_full", out_valid, 1);
      #2 rst_n = 0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_addr", out_addr, 0);
      chk("arst_in0_ready", in0_ready, 0);
      in0_valid = 0;
      tick();
      tick();
      rst_n = 1; out_ready = 1;
      tick();
      @(negedge clk);
      chk("postrst_empty", out_valid, 0);
      tick();
      in0_valid = 1; in1_valid = 1;
      in0_addr = 3; in0_data = 32'h33333333;
      in1_addr = 4; in1_data = 32'h44444444;
      @(negedge clk);
      chk("postrst_tie_in0", in0_ready, 1);
      push(0, 3, 32'h33333333);
      tick();
      in0_valid = 0; in1_valid = 0;
      @(negedge clk);
      tick();
      chk("scoreboard_empty", exp_q.size(), 0);

`ifdef WPORT_ARB_STATS_EN
      rst_n = 0;
      #1;
      chk("cnt_rst0", gnt_cnt0, 0);
      tick();
      rst_n = 1;
      in0_valid = 1; in0_addr = 0; in0_data = 32'hFFFFFFFF;
      repeat (70000) @(posedge clk);
      #1;
      in0_valid = 0;
      chk("cnt0_sat", gnt_cnt0, 16'hFFFF);
      chk("cnt1_zero", gnt_cnt1, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wport_arb_2_1.md
WPORT_ARB_2_1 -- requirements
Module: wport_arb_2_1

Interface
REQ-001 Parameter DATA_W, default 32, width of the write-data path.
REQ-002 Parameter ADDR_W, default 5, width of the register write address.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in0_valid  input  1  requester 0 (ALU result path) has a write pending.
REQ-006 in0_ready  output  1  requester 0 write accepted this cycle when high with in0_valid.
REQ-007 in0_addr  input  ADDR_W  requester 0 destination register.
REQ-008 in0_data  input  DATA_W  requester 0 write data.
REQ-009 in1_valid, in1_ready, in1_addr, in1_data: same as REQ-005..008 for requester 1 (load path).
REQ-010 out_valid  output  1  registered write presented to the register-file port.
REQ-011 out_ready  input  1  register-file port consumes the presented write.
REQ-012 out_addr  output  ADDR_W  registered destination register.
REQ-013 out_data  output  DATA_W  registered write data.
REQ-014 out_src  output  1  index of the requester that produced the presented write.

Function
REQ-015 Transfer on input i is in_i_valid && in_i_ready; transfer on output is out_valid && out_ready.
REQ-016 Output stage has two states, EMPTY (out_valid=0) and FULL (out_valid=1); it can accept ("open") when EMPTY, or FULL with out_ready=1.
REQ-017 When open, exactly one valid requester is granted; in_i_ready=1 only for the granted requester, 0 otherwise; nothing granted when closed.
REQ-018 Single valid requester: it is granted. Both valid: the requester not equal to last_grant is granted (round-robin).
REQ-019 last_grant updates to the granted index on every input transfer; unchanged otherwise.
REQ-020 in_ready SHALL be combinational from valids, last_grant, out_valid, out_ready only; it SHALL NOT depend on addr/data.
REQ-021 Input transfer with addr != 0: next cycle out_valid=1, out_addr/out_data/out_src = granted requester values (latency 1).
REQ-022 Input transfer with addr == 0 ($zero): accepted, last_grant updated, but not forwarded; stage goes/stays EMPTY unless otherwise loaded.
REQ-023 FULL with out_ready=0: out_addr/out_data/out_src held stable, both in_ready=0.
REQ-024 FULL with out_ready=1 and an input transfer in the same cycle: new write loaded, out_valid stays 1, no bubble.
REQ-025 FULL with out_ready=1 and no input transfer: out_valid=0 next cycle.
REQ-026 Data selection between requesters SHALL use a 32-bit 2:1 select on out_src semantics (in0 when grant=0, in1 when grant=1).

Reset
REQ-027 rst_n low SHALL immediately force out_valid=0, out_addr=0, out_data=0, out_src=0, last_grant=1 (requester 0 wins the first tie).
REQ-028 Reset asserted mid-transfer discards the held write; no write is presented after rst_n deasserts until a new input transfer.
REQ-029 in_ready outputs SHALL be 0 while rst_n is low.

Configuration
REQ-030 Macro WPORT_ARB_STATS_EN: when defined, add outputs gnt_cnt0 and gnt_cnt1 (16 bits each), counting input transfers per requester, saturating at 16'hFFFF, reset to 0; $zero transfers counted.
REQ-031 Without WPORT_ARB_STATS_EN the counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 After reset, in0_valid=in1_valid=1, addr 3/4, data 0x11111111/0x22222222, out_ready=1 -> grants alternate 0,1,0,1; out_data sequence 0x11111111,0x22222222,... one per cycle.
REQ-033 Only in1_valid=1, addr 7, data 0xDEADBEEF, out_ready=0 for 3 cycles -> out_valid=1 with addr 7/data 0xDEADBEEF held 3 cycles, in1_ready=0, both ready=0 until out_ready=1.
REQ-034 in0 transfer addr 0 data 0xFFFFFFFF -> in0_ready=1, out_valid stays 0, next tie granted to requester 1.
REQ-035 Continuous in0 stream with out_ready=1 -> out_valid=1 every cycle after first, no bubbles, out_src=0.
REQ-036 rst_n pulsed low while FULL and out_ready=0 -> out_valid=0 asynchronously, out_data=0, last_grant=1.
REQ-037 With WPORT_ARB_STATS_EN, 70000 in0 transfers -> gnt_cnt0=0xFFFF, gnt_cnt1=0.
